// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a single-port, 1-cycle-latency synchronous SRAM.
// Data accesses have fixed priority over instruction fetch; a starvation
// counter forces a fetch grant after STARVE_MAX consecutive fetch denials.
// A one-entry response tag steers the read data back to the issuing side.
//
// Handshake: a requester raises req with stable addr/wen/wdata and holds it
// until gnt is seen high in the same cycle; the access is accepted on that
// edge. Reads return rvalid/rdata exactly one cycle after the grant; writes
// complete at the grant and never produce rvalid.
module sram_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  // instruction fetch side
  input  logic             inst_req,
  input  logic [31:0]      inst_addr,
  output logic             inst_gnt,
  output logic             inst_rvalid,
  output logic [31:0]      inst_rdata,
  // data load/store side
  input  logic             data_req,
  input  logic [3:0]       data_wen,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_gnt,
  output logic             data_rvalid,
  output logic [31:0]      data_rdata,
  // SRAM macro side
  output logic             sram_en,
  output logic [3:0]       sram_wen,
  output logic [31:0]      sram_addr,
  output logic [31:0]      sram_wdata,
  input  logic [31:0]      sram_rdata,
  // debug view of internal state
  output logic [1:0]       dbg_rsp_owner,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  owner_e           rsp_owner;
  owner_e           rsp_owner_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             force_inst;

  // Grant decision: data first, unless fetch has been starved to the limit.
  always_comb begin
    force_inst = (starve_cnt == STARVE_LIM);
    data_gnt   = ~reset & data_req & ~(inst_req & force_inst);
    inst_gnt   = ~reset & inst_req & ~data_gnt;
  end

  // SRAM port mux: drive the granted requester, otherwise park at zero.
  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_wen   = 4'h0;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    if (data_gnt) begin
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_addr  = inst_addr;
    end
  end

  // Next response owner and starvation count.
  always_comb begin
    rsp_owner_nxt  = OWN_NONE;
    starve_cnt_nxt = '0;
    if (inst_gnt) begin
      rsp_owner_nxt = OWN_INST;
    end else if (data_gnt && (data_wen == 4'h0)) begin
      rsp_owner_nxt = OWN_DATA;
    end
    if (inst_req && !inst_gnt) begin
      starve_cnt_nxt = force_inst ? starve_cnt : starve_cnt + CNT_W'(1);
    end
  end

  // State registers; reset drops any outstanding response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_owner  <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      rsp_owner  <= rsp_owner_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Response routing; rvalid is masked while reset is held so a read
  // granted just before reset never reports.
  always_comb begin
    inst_rvalid    = ~reset & (rsp_owner == OWN_INST);
    data_rvalid    = ~reset & (rsp_owner == OWN_DATA);
    inst_rdata     = sram_rdata;
    data_rdata     = sram_rdata;
    dbg_rsp_owner  = rsp_owner;
    dbg_starve_cnt = starve_cnt;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an SRAM environment model,
// a per-cycle behavioural reference checker and literal spot checks.
module tb_sram_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             inst_req = 1'b0;
  logic [31:0]      inst_addr = 32'h0;
  logic             inst_gnt, inst_rvalid;
  logic [31:0]      inst_rdata;
  logic             data_req = 1'b0;
  logic [3:0]       data_wen = 4'h0;
  logic [31:0]      data_addr = 32'h0;
  logic [31:0]      data_wdata = 32'h0;
  logic             data_gnt, data_rvalid;
  logic [31:0]      data_rdata;
  logic             sram_en;
  logic [3:0]       sram_wen;
  logic [31:0]      sram_addr, sram_wdata;
  logic [31:0]      sram_rdata = 32'h0;
  logic [1:0]       dbg_rsp_owner;
  logic [CNT_W-1:0] dbg_starve_cnt;

  sram_port_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .dbg_rsp_owner(dbg_rsp_owner), .dbg_starve_cnt(dbg_starve_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM environment ----------------
  // Unwritten words read back as addr ^ 0xFFFF0000.
  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] mdl_mem[logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hFFFF0000;
  endfunction

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen == 4'h0) begin
        sram_rdata <= env_mem.exists(sram_addr) ? env_mem[sram_addr] : dflt(sram_addr);
      end else begin
        logic [31:0] w;
        w = env_mem.exists(sram_addr) ? env_mem[sram_addr] : dflt(sram_addr);
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
        env_mem[sram_addr] = w;
      end
    end
  end

  // ---------------- reference model + compare ----------------
  // Model state: consecutive fetch denials, and who (if anyone) expects a
  // read response next cycle together with the word it should see.
  int          m_denials = 0;
  int          m_pend    = 0;   // 0 none, 1 fetch, 2 data
  logic [31:0] m_pend_word = 32'h0;

  always @(negedge clk) begin
    logic        e_ig, e_dg;
    logic [3:0]  e_wen;
    logic [31:0] e_addr, e_wdata, w;
    e_ig = 1'b0; e_dg = 1'b0;
    if (!reset) begin
      if (inst_req && m_denials >= STARVE_MAX) e_ig = 1'b1;
      else if (data_req)                       e_dg = 1'b1;
      else if (inst_req)                       e_ig = 1'b1;
    end
    e_wen = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    if (e_dg) begin e_wen = data_wen; e_addr = data_addr; e_wdata = data_wdata; end
    if (e_ig) e_addr = inst_addr;

    chk("m_inst_gnt", 32'(inst_gnt), 32'(e_ig));
    chk("m_data_gnt", 32'(data_gnt), 32'(e_dg));
    chk("m_sram_en", 32'(sram_en), 32'(e_ig | e_dg));
    chk("m_sram_wen", 32'(sram_wen), 32'(e_wen));
    chk("m_sram_addr", sram_addr, e_addr);
    chk("m_sram_wdata", sram_wdata, e_wdata);
    chk("m_starve_cnt", 32'(dbg_starve_cnt), 32'(m_denials));
    chk("m_inst_rvalid", 32'(inst_rvalid), 32'(!reset && m_pend == 1));
    chk("m_data_rvalid", 32'(data_rvalid), 32'(!reset && m_pend == 2));
    if (!reset && m_pend == 1) chk("m_inst_rdata", inst_rdata, m_pend_word);
    if (!reset && m_pend == 2) chk("m_data_rdata", data_rdata, m_pend_word);

    // advance model to next cycle
    if (reset) begin
      m_denials = 0;
      m_pend    = 0;
    end else begin
      if (inst_req && !e_ig) m_denials = (m_denials < STARVE_MAX) ? m_denials + 1 : STARVE_MAX;
      else                   m_denials = 0;
      m_pend = 0;
      if (e_ig) begin
        m_pend = 1;
        m_pend_word = mdl_mem.exists(inst_addr) ? mdl_mem[inst_addr] : dflt(inst_addr);
      end else if (e_dg) begin
        w = mdl_mem.exists(data_addr) ? mdl_mem[data_addr] : dflt(data_addr);
        if (data_wen == 4'h0) begin
          m_pend = 2;
          m_pend_word = w;
        end else begin
          for (int b = 0; b < 4; b++)
            if (data_wen[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
          mdl_mem[data_addr] = w;
        end
      end
    end
  end

  // ---------------- requester rule monitor ----------------
  bit          allow_drop = 1'b0;
  logic        p_ireq = 1'b0, p_ignt = 1'b0, p_dreq = 1'b0, p_dgnt = 1'b0;
  logic [31:0] p_iaddr, p_daddr, p_dwdata;
  logic [3:0]  p_dwen;

  always @(negedge clk) begin
    if (p_ireq && !p_ignt) begin
      if (!allow_drop) chk("rule_inst_hold", 32'(inst_req), 32'd1);
      if (inst_req) chk("rule_inst_addr", inst_addr, p_iaddr);
    end
    if (p_dreq && !p_dgnt) begin
      chk("rule_data_hold", 32'(data_req), 32'd1);
      chk("rule_data_addr", data_addr, p_daddr);
      chk("rule_data_wen", 32'(data_wen), 32'(p_dwen));
      chk("rule_data_wdata", data_wdata, p_dwdata);
    end
    p_ireq = inst_req; p_ignt = inst_gnt; p_iaddr = inst_addr;
    p_dreq = data_req; p_dgnt = data_gnt; p_daddr = data_addr;
    p_dwen = data_wen; p_dwdata = data_wdata;
  end

  // ---------------- driver tasks ----------------
  logic        s_ig, s_dg, s_irv, s_drv, s_en;
  logic [31:0] s_ird, s_drd, s_addr, s_wdata;
  logic [3:0]  s_wen;
  logic [CNT_W-1:0] s_cnt;

  // Let one cycle elapse: snapshot outputs mid-cycle, then move to just
  // after the next rising edge where new inputs are applied.
  task automatic tick();
    @(negedge clk);
    s_ig = inst_gnt; s_dg = data_gnt; s_irv = inst_rvalid; s_drv = data_rvalid;
    s_ird = inst_rdata; s_drd = data_rdata; s_addr = sram_addr; s_wen = sram_wen;
    s_wdata = sram_wdata; s_en = sram_en; s_cnt = dbg_starve_cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input bit drop);
    if (inst_req && s_ig) begin
      if (drop) inst_req = 1'b0; else inst_addr = inst_addr + 32'd4;
    end
    if (data_req && s_dg) begin
      if (drop) data_req = 1'b0; else data_addr = data_addr + 32'd4;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((inst_req || data_req) && n < 20) begin
      tick();
      advance(1'b1);
      n++;
    end
    if (inst_req || data_req) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: requests still pending after %0d cycles", n);
      inst_req = 1'b0;
      data_req = 1'b0;
    end
    tick();
    tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // reset
    tick();
    chk("rst_inst_gnt", 32'(s_ig), 32'd0);
    chk("rst_data_gnt", 32'(s_dg), 32'd0);
    chk("rst_sram_en", 32'(s_en), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_inst_rvalid", 32'(s_irv), 32'd0);
    chk("post_rst_data_rvalid", 32'(s_drv), 32'd0);
    chk("post_rst_cnt", 32'(s_cnt), 32'd0);

    // fetch only
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fetch_gnt", 32'(s_ig), 32'd1);
      if (k == 0) chk("fetch_addr0", s_addr, 32'h1c000000);
      if (k == 1) begin
        chk("fetch_rvalid1", 32'(s_irv), 32'd1);
        chk("fetch_rdata1", s_ird, 32'hE3FF0000);
      end
      advance(1'b0);
    end
    drain();

    // data read priority
    inst_req = 1'b1; inst_addr = 32'h1c000100;
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h100; data_wdata = 32'h0;
    tick();
    chk("prio_data_gnt", 32'(s_dg), 32'd1);
    chk("prio_inst_gnt", 32'(s_ig), 32'd0);
    chk("prio_sram_addr", s_addr, 32'h100);
    data_req = 1'b0;
    tick();
    chk("prio_data_rvalid", 32'(s_drv), 32'd1);
    chk("prio_inst_rvalid", 32'(s_irv), 32'd0);
    chk("prio_data_rdata", s_drd, 32'hFFFF0100);
    chk("prio_inst_gnt_next", 32'(s_ig), 32'd1);
    inst_req = 1'b0;
    tick();
    chk("prio_inst_rvalid2", 32'(s_irv), 32'd1);
    chk("prio_inst_rdata2", s_ird, 32'hE3FF0100);
    tick();

    // starvation: D,D,D,D,I repeating
    inst_req = 1'b1; inst_addr = 32'h1c000200;
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("starve_inst_gnt", 32'(s_ig), 32'((k % 5) == 4));
      chk("starve_data_gnt", 32'(s_dg), 32'((k % 5) != 4));
      chk("starve_cnt", 32'(s_cnt), 32'(k % 5));
      advance(1'b0);
    end
    drain();

    // store then read back
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h200; data_wdata = 32'hDEADBEEF;
    tick();
    chk("store_gnt", 32'(s_dg), 32'd1);
    chk("store_sram_wen", 32'(s_wen), 32'h3);
    chk("store_sram_wdata", s_wdata, 32'hDEADBEEF);
    data_wen = 4'h0; data_wdata = 32'h0;
    tick();
    chk("store_no_data_rvalid", 32'(s_drv), 32'd0);
    chk("store_no_inst_rvalid", 32'(s_irv), 32'd0);
    chk("store_read_gnt", 32'(s_dg), 32'd1);
    data_req = 1'b0;
    tick();
    chk("store_read_rvalid", 32'(s_drv), 32'd1);
    chk("store_read_rdata", s_drd, 32'hFFFFBEEF);
    tick();

    // reset with a fetch read outstanding
    inst_req = 1'b1; inst_addr = 32'h1c000300;
    tick();
    chk("rstmid_gnt_n", 32'(s_ig), 32'd1);
    inst_req = 1'b0; reset = 1'b1;
    tick();
    chk("rstmid_rvalid_n1", 32'(s_irv), 32'd0);
    chk("rstmid_gnt_n1", 32'(s_ig), 32'd0);
    inst_req = 1'b1; inst_addr = 32'h1c000304;
    tick();
    chk("rstmid_rvalid_n2", 32'(s_irv), 32'd0);
    chk("rstmid_gnt_n2", 32'(s_ig), 32'd0);
    reset = 1'b0;
    tick();
    chk("rstmid_first_gnt", 32'(s_ig), 32'd1);
    chk("rstmid_rvalid_n3", 32'(s_irv), 32'd0);
    inst_req = 1'b0;
    tick();
    chk("rstmid_new_rvalid", 32'(s_irv), 32'd1);
    chk("rstmid_new_rdata", s_ird, 32'hE3FF0304);
    tick();

    // alternating fetch request with continuous data reads
    allow_drop = 1'b1;
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h400;
    inst_addr = 32'h1c000400;
    for (int k = 0; k < 8; k++) begin
      inst_req = ((k % 2) == 0);
      tick();
      chk("alt_data_gnt", 32'(s_dg), 32'd1);
      chk("alt_inst_gnt", 32'(s_ig), 32'd0);
      chk("alt_cnt", 32'(s_cnt), 32'(k % 2));
      advance(1'b0);
    end
    inst_req = 1'b0;
    drain();
    allow_drop = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
